// File: rtl/iwrite_controller.sv
// Activation write controller: round-robin IBRAM bank writer with ping-pong halves and layer-param table.
// Optional build macro IWRITE_STALL_CNT_EN adds the stall_cycles output counter.
`timescale 1ns/1ps
module iwrite_controller #(
   parameter int NUM_BANKS   = 4,
   parameter int WRITE_WIDTH = 64,
   parameter int WRITE_DEPTH = 512,
   parameter int PARAM_WIDTH = 32,
   parameter int PARAM_DEPTH = 16
) (
   input  logic                                          clk,
   input  logic                                          rst_n,
   input  logic [WRITE_WIDTH-1:0]                        s_act_data,
   input  logic                                          s_act_valid,
   input  logic                                          s_act_last,
   output logic                                          s_act_ready,
   output logic [NUM_BANKS-1:0]                          enaA,
   output logic [NUM_BANKS-1:0]                          weA,
   output logic [$clog2(WRITE_DEPTH):0]                  addrA_ping_pong,
   output logic [WRITE_WIDTH-1:0]                        diA,
   output logic [NUM_BANKS*($clog2(WRITE_DEPTH)+1)-1:0]  write_addr_pingpong_data,
   input  logic                                          buf_release,
   output logic                                          err_release,
`ifdef IWRITE_STALL_CNT_EN
   output logic [31:0]                                   stall_cycles,
`endif
   input  logic                                          cfg_wr_en,
   input  logic [$clog2(PARAM_DEPTH)-1:0]                cfg_wr_addr,
   input  logic [PARAM_WIDTH-1:0]                        cfg_wr_data,
   input  logic [PARAM_WIDTH-1:0]                        param_addr_rd,
   input  logic                                          param_addr_valid_rd,
   output logic                                          param_addr_ready_rd,
   output logic [PARAM_WIDTH-1:0]                        param_data_rd,
   output logic                                          param_data_valid_rd,
   input  logic                                          param_data_ready_rd
);

   localparam int AW = $clog2(WRITE_DEPTH);
   localparam int BW = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
   localparam int PA = $clog2(PARAM_DEPTH);

   typedef enum logic {FILL, FULL_WAIT} state_t;

   state_t          state_q, state_d;
   logic [BW-1:0]   bank_sel_q;
   logic [AW-1:0]   addr_q;
   logic            pp_q;
   logic [1:0]      halves_q;
   logic            done_q;
   logic [AW:0]     ptr_q [NUM_BANKS];
   logic            acc, done, rel_ok;

   assign acc    = s_act_valid & s_act_ready;
   assign done   = acc & (s_act_last |
                   ((bank_sel_q == BW'(NUM_BANKS-1)) &&
                    (addr_q == AW'(WRITE_DEPTH-1))));
   assign rel_ok = buf_release & (halves_q != 2'd0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= FILL;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         FILL:      if (done && !rel_ok && halves_q == 2'd1)
                       state_d = FULL_WAIT;
         FULL_WAIT: if (rel_ok) state_d = FILL;
         default:   state_d = FILL;
      endcase
   end

   always_comb begin
      s_act_ready = (state_q == FILL);
   end

   // Bank/address walk and the registered port-A write.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bank_sel_q      <= '0;
         addr_q          <= '0;
         pp_q            <= 1'b0;
         enaA            <= '0;
         addrA_ping_pong <= '0;
         diA             <= '0;
         done_q          <= 1'b0;
      end else begin
         done_q <= done;
         if (acc) begin
            enaA            <= NUM_BANKS'(1) << bank_sel_q;
            addrA_ping_pong <= {addr_q, pp_q};
            diA             <= s_act_data;
         end else begin
            enaA <= '0;
         end
         if (done) begin
            pp_q       <= ~pp_q;
            addr_q     <= '0;
            bank_sel_q <= '0;
         end else if (acc) begin
            if (bank_sel_q == BW'(NUM_BANKS-1)) begin
               bank_sel_q <= '0;
               addr_q     <= addr_q + AW'(1);
            end else begin
               bank_sel_q <= bank_sel_q + BW'(1);
            end
         end
      end
   end

   assign weA = enaA;

   // Pointers follow the registered write, so they never lead the data.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int b = 0; b < NUM_BANKS; b++) ptr_q[b] <= '0;
      end else begin
         for (int b = 0; b < NUM_BANKS; b++) begin
            if (done_q)
               ptr_q[b] <= {pp_q, {AW{1'b0}}};
            else if (enaA[b])
               ptr_q[b] <= {addrA_ping_pong[0],
                            addrA_ping_pong[AW:1] + AW'(1)};
         end
      end
   end

   always_comb begin
      write_addr_pingpong_data = '0;
      for (int b = 0; b < NUM_BANKS; b++)
         write_addr_pingpong_data[b*(AW+1) +: AW+1] = ptr_q[b];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         halves_q    <= 2'd0;
         err_release <= 1'b0;
      end else begin
         if (buf_release && halves_q == 2'd0) err_release <= 1'b1;
         unique case ({done, rel_ok})
            2'b10:   halves_q <= halves_q + 2'd1;
            2'b01:   halves_q <= halves_q - 2'd1;
            default: halves_q <= halves_q;
         endcase
      end
   end

`ifdef IWRITE_STALL_CNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         stall_cycles <= '0;
      else if (s_act_valid && !s_act_ready && stall_cycles != '1)
         stall_cycles <= stall_cycles + 32'd1;
   end
`endif

   logic [PARAM_WIDTH-1:0] ptab_q [PARAM_DEPTH];
   logic                   unused_addr_bits;
   logic                   rd_hs;

   assign unused_addr_bits    = ^param_addr_rd[PARAM_WIDTH-1:PA];
   assign param_addr_ready_rd = ~param_data_valid_rd | param_data_ready_rd;
   assign rd_hs               = param_addr_valid_rd & param_addr_ready_rd;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < PARAM_DEPTH; i++) ptab_q[i] <= '0;
      end else if (cfg_wr_en) begin
         ptab_q[cfg_wr_addr] <= cfg_wr_data;
      end
   end

   // Read sees the pre-edge table, so a same-cycle write returns old data.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         param_data_rd       <= '0;
         param_data_valid_rd <= 1'b0;
      end else if (rd_hs) begin
         param_data_rd       <= ptab_q[param_addr_rd[PA-1:0]];
         param_data_valid_rd <= 1'b1;
      end else if (param_data_ready_rd) begin
         param_data_valid_rd <= 1'b0;
      end
   end

endmodule

// File: tb/tb_iwrite_controller.sv
// Self-checking bench for iwrite_controller: scoreboard on port-A writes plus per-scenario tasks.
`timescale 1ns/1ps
module tb_iwrite_controller;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [63:0]  s_act_data;
   logic         s_act_valid, s_act_last, s_act_ready;
   logic [3:0]   enaA, weA;
   logic [9:0]   addrA_ping_pong;
   logic [63:0]  diA;
   logic [39:0]  write_addr_pingpong_data;
   logic         buf_release, err_release;
   logic         cfg_wr_en;
   logic [3:0]   cfg_wr_addr;
   logic [31:0]  cfg_wr_data;
   logic [31:0]  param_addr_rd;
   logic         param_addr_valid_rd, param_addr_ready_rd;
   logic [31:0]  param_data_rd;
   logic         param_data_valid_rd, param_data_ready_rd;
`ifdef IWRITE_STALL_CNT_EN
   logic [31:0]  stall_cycles;
`endif

   iwrite_controller dut (
      .clk(clk), .rst_n(rst_n),
      .s_act_data(s_act_data), .s_act_valid(s_act_valid),
      .s_act_last(s_act_last), .s_act_ready(s_act_ready),
      .enaA(enaA), .weA(weA), .addrA_ping_pong(addrA_ping_pong), .diA(diA),
      .write_addr_pingpong_data(write_addr_pingpong_data),
      .buf_release(buf_release), .err_release(err_release),
`ifdef IWRITE_STALL_CNT_EN
      .stall_cycles(stall_cycles),
`endif
      .cfg_wr_en(cfg_wr_en), .cfg_wr_addr(cfg_wr_addr), .cfg_wr_data(cfg_wr_data),
      .param_addr_rd(param_addr_rd), .param_addr_valid_rd(param_addr_valid_rd),
      .param_addr_ready_rd(param_addr_ready_rd), .param_data_rd(param_data_rd),
      .param_data_valid_rd(param_data_valid_rd), .param_data_ready_rd(param_data_ready_rd)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [3:0]  ena;
      logic [9:0]  ap;
      logic [63:0] d;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;
   int   mbank, maddr;
   bit   mpp;

   function automatic logic [9:0] ptr(input int b);
      return write_addr_pingpong_data[b*10 +: 10];
   endfunction

   // Scoreboard: every visible write must match the oldest accepted beat.
   always @(negedge clk) begin
      if (rst_n && enaA !== 4'b0) begin
         exp_t e;
         checks++;
         if (q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_write enaA=%b", enaA);
         end else begin
            e = q.pop_front();
            if (enaA !== e.ena || weA !== e.ena || addrA_ping_pong !== e.ap || diA !== e.d) begin
               errors++;
               $display("FAIL write got ena=%b we=%b ap=%h d=%h want ena=%b ap=%h d=%h",
                        enaA, weA, addrA_ping_pong, diA, e.ena, e.ap, e.d);
            end
         end
      end
   end

   task automatic model_reset();
      q.delete();
      mbank = 0; maddr = 0; mpp = 1'b0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   // Called at a negedge; returns at the negedge after acceptance.
   task automatic send(input logic [63:0] d, input bit last);
      int n = 0;
      exp_t e;
      s_act_valid = 1'b1; s_act_data = d; s_act_last = last;
      while (!s_act_ready && n < 50) begin @(negedge clk); n++; end
      if (!s_act_ready) begin
         checks++; errors++;
         $display("FAIL send_timeout ready=%b want 1", s_act_ready);
         s_act_valid = 1'b0; s_act_last = 1'b0;
         return;
      end
      e.ena = 4'b1 << mbank;
      e.ap  = {maddr[8:0], mpp};
      e.d   = d;
      q.push_back(e);
      if (last || (mbank == 3 && maddr == 511)) begin
         mpp = ~mpp; mbank = 0; maddr = 0;
      end else if (mbank == 3) begin
         mbank = 0; maddr++;
      end else begin
         mbank++;
      end
      @(negedge clk);
      s_act_valid = 1'b0; s_act_last = 1'b0;
   endtask

   task automatic release_pulse();
      buf_release = 1'b1;
      @(negedge clk);
      buf_release = 1'b0;
   endtask

   task automatic chk_ready(input logic want, input string tag);
      checks++;
      if (s_act_ready !== want) begin
         errors++;
         $display("FAIL %s ready=%b want %b", tag, s_act_ready, want);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #3;
      checks++;
      if (enaA !== 0 || weA !== 0 || addrA_ping_pong !== 0 || diA !== 0 ||
          write_addr_pingpong_data !== 0 || err_release !== 0 || param_data_valid_rd !== 0 ||
          param_data_rd !== 0) begin
         errors++;
         $display("FAIL reset_outputs ena=%b ap=%h ptrs=%h err=%b pv=%b",
                  enaA, addrA_ping_pong, write_addr_pingpong_data, err_release, param_data_valid_rd);
      end
`ifdef IWRITE_STALL_CNT_EN
      checks++;
      if (stall_cycles !== 0) begin
         errors++;
         $display("FAIL reset_stall got %0d want 0", stall_cycles);
      end
`endif
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      @(negedge clk);
      chk_ready(1'b1, "reset_ready");
   endtask

   task automatic chk_param(input logic [31:0] want, input logic vwant,
                            input logic awant, input string tag);
      checks++;
      if (param_data_valid_rd !== vwant || (vwant && param_data_rd !== want) ||
          param_addr_ready_rd !== awant) begin
         errors++;
         $display("FAIL %s data=%h valid=%b aready=%b want data=%h valid=%b aready=%b",
                  tag, param_data_rd, param_data_valid_rd, param_addr_ready_rd, want, vwant, awant);
      end
   endtask

   task automatic test_param();
      cfg_wr_en = 1'b1; cfg_wr_addr = 4'd0; cfg_wr_data = 32'h3;
      @(negedge clk);
      cfg_wr_addr = 4'd1; cfg_wr_data = 32'hA5A5_0001;
      @(negedge clk);
      cfg_wr_en = 1'b0;
      param_data_ready_rd = 1'b0;
      param_addr_rd = 32'hFFFF_FF11; param_addr_valid_rd = 1'b1;
      chk_param(32'h0, 1'b0, 1'b1, "param_idle");
      @(negedge clk);
      param_addr_valid_rd = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk_param(32'hA5A5_0001, 1'b1, 1'b0, "param_hold");
         if (i < 2) @(negedge clk);
      end
      param_data_ready_rd = 1'b1;
      #1 chk_param(32'hA5A5_0001, 1'b1, 1'b1, "param_drain");
      @(negedge clk);
      chk_param(32'h0, 1'b0, 1'b1, "param_empty");
      param_addr_rd = 32'h0; param_addr_valid_rd = 1'b1;
      @(negedge clk);
      chk_param(32'h3, 1'b1, 1'b1, "param_b2b0");
      param_addr_rd = 32'h1;
      @(negedge clk);
      chk_param(32'hA5A5_0001, 1'b1, 1'b1, "param_b2b1");
      cfg_wr_en = 1'b1; cfg_wr_addr = 4'd0; cfg_wr_data = 32'h77;
      param_addr_rd = 32'h0;
      @(negedge clk);
      cfg_wr_en = 1'b0;
      chk_param(32'h3, 1'b1, 1'b1, "param_rw_old");
      @(negedge clk);
      param_addr_valid_rd = 1'b0;
      chk_param(32'h77, 1'b1, 1'b1, "param_rw_new");
      @(negedge clk);
   endtask

   task automatic test_fill8();
      do_reset();
      send(64'h100, 1'b0);
      checks++;
      if (ptr(0) !== 10'd0) begin
         errors++;
         $display("FAIL ptr_lead got %h want 000", ptr(0));
      end
      send(64'h101, 1'b0);
      checks++;
      if (ptr(0) !== 10'd1) begin
         errors++;
         $display("FAIL ptr_follow got %h want 001", ptr(0));
      end
      for (int i = 2; i < 8; i++) send(64'h100 + 64'(i), 1'b0);
      @(negedge clk);
      for (int b = 0; b < 4; b++) begin
         checks++;
         if (ptr(b) !== 10'd2) begin
            errors++;
            $display("FAIL fill8_ptr%0d got %h want 002", b, ptr(b));
         end
      end
   endtask

   task automatic test_last();
      do_reset();
      for (int i = 0; i < 6; i++) send(64'h200 + 64'(i), i == 5);
      @(negedge clk);
      for (int b = 0; b < 4; b++) begin
         checks++;
         if (ptr(b) !== 10'h200) begin
            errors++;
            $display("FAIL last_ptr%0d got %h want 200", b, ptr(b));
         end
      end
      send(64'h2FF, 1'b0);
      checks++;
      if (enaA !== 4'b0001 || addrA_ping_pong !== 10'h001) begin
         errors++;
         $display("FAIL last_next ena=%b ap=%h want 0001 001", enaA, addrA_ping_pong);
      end
      chk_ready(1'b1, "last_ready");
   endtask

   task automatic test_two_halves();
      do_reset();
      send(64'h300, 1'b0); send(64'h301, 1'b1);
      chk_ready(1'b1, "half1_ready");
      send(64'h302, 1'b0); send(64'h303, 1'b1);
      chk_ready(1'b0, "half2_stall");
      s_act_valid = 1'b1;
      repeat (3) @(negedge clk);
      s_act_valid = 1'b0;
`ifdef IWRITE_STALL_CNT_EN
      checks++;
      if (stall_cycles !== 32'd3) begin
         errors++;
         $display("FAIL stall_cnt got %0d want 3", stall_cycles);
      end
`endif
      chk_ready(1'b0, "full_hold");
      release_pulse();
      chk_ready(1'b1, "release_ready");
      send(64'h304, 1'b1);
      chk_ready(1'b0, "refill_stall");
      release_pulse();
      chk_ready(1'b1, "release2_ready");
   endtask

   task automatic test_back_to_back();
      buf_release = 1'b1;
      send(64'h400, 1'b1);
      buf_release = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk_ready(1'b1, "simul_ready");
         @(negedge clk);
      end
      send(64'h401, 1'b1);
      chk_ready(1'b0, "simul_count");
      release_pulse();
      release_pulse();
      chk_ready(1'b1, "drain_ready");
      checks++;
      if (err_release !== 1'b0) begin
         errors++;
         $display("FAIL err_early got %b want 0", err_release);
      end
   endtask

   task automatic test_err_release();
      release_pulse();
      for (int i = 0; i < 2; i++) begin
         checks++;
         if (err_release !== 1'b1) begin
            errors++;
            $display("FAIL err_sticky got %b want 1", err_release);
         end
         @(negedge clk);
      end
      send(64'h500, 1'b1);
      chk_ready(1'b1, "err_cnt1");
      send(64'h501, 1'b1);
      chk_ready(1'b0, "err_cnt2");
      checks++;
      if (err_release !== 1'b1) begin
         errors++;
         $display("FAIL err_hold got %b want 1", err_release);
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      for (int i = 0; i < 22; i++) send(64'h600 + 64'(i), 1'b0);
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (enaA !== 0 || addrA_ping_pong !== 0 || diA !== 0 ||
          write_addr_pingpong_data !== 0 || err_release !== 0) begin
         errors++;
         $display("FAIL async_reset ena=%b ap=%h d=%h ptrs=%h",
                  enaA, addrA_ping_pong, diA, write_addr_pingpong_data);
      end
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      send(64'hBEEF, 1'b0);
      checks++;
      if (enaA !== 4'b0001 || addrA_ping_pong !== 10'h000) begin
         errors++;
         $display("FAIL post_reset ena=%b ap=%h want 0001 000", enaA, addrA_ping_pong);
      end
   endtask

   initial begin
      rst_n = 1'b0;
      s_act_data = '0; s_act_valid = 1'b0; s_act_last = 1'b0;
      buf_release = 1'b0;
      cfg_wr_en = 1'b0; cfg_wr_addr = '0; cfg_wr_data = '0;
      param_addr_rd = '0; param_addr_valid_rd = 1'b0; param_data_ready_rd = 1'b1;
      model_reset();
      @(negedge clk);
      test_reset();
      test_param();
      test_fill8();
      test_last();
      test_two_halves();
      test_back_to_back();
      test_err_release();
      test_reset_mid();
      @(negedge clk);
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_left got %0d want 0", q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
